// File: rtl/fb_scan_reader.sv
// Framebuffer scan-out reader: walks one H_RES x V_RES frame from a base address over a
// single-port bram read port and presents the pixels as a valid/ready stream with line/frame tags.
module fb_scan_reader #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 24,
  parameter int H_RES      = 64,
  parameter int V_RES      = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_cen,
  output logic                  mem_wen,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_dout,
  output logic                  pix_valid,
  input  logic                  pix_ready,
  output logic [DATA_WIDTH-1:0] pix_data,
  output logic                  pix_eol,
  output logic                  pix_last
);

  localparam int TOTAL = H_RES * V_RES;
  localparam int KW    = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam int XW    = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int YW    = (V_RES > 1) ? $clog2(V_RES) : 1;

  localparam logic [KW-1:0] K_LAST = KW'(TOTAL - 1);
  localparam logic [XW-1:0] X_LAST = XW'(H_RES - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_RES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e                  state_q;
  logic                    busy_q;
  logic                    done_q;
  logic [ADDR_WIDTH-1:0]   next_addr_q;
  logic [ADDR_WIDTH-1:0]   last_addr_q;
  logic [KW-1:0]           k_q;
  logic [XW-1:0]           x_q;
  logic [YW-1:0]           y_q;
  logic                    pend_q;
  logic                    pend_eol_q;
  logic                    pend_last_q;

  logic [DATA_WIDTH-1:0]   fifo_data_q [2];
  logic [1:0]              fifo_eol_q;
  logic [1:0]              fifo_last_q;
  logic                    rd_ptr_q;
  logic                    wr_ptr_q;
  logic [1:0]              occ_q;
  logic [1:0]              occ_d;

  logic                    pop_s;
  logic                    issue_s;
  logic                    eol_s;
  logic                    last_s;
  logic                    last_issue_s;
  logic                    head_last_s;
  logic [2:0]              demand_s;

  // Issue a read only if the FIFO can still hold it once every in-flight read has landed.
  always_comb begin
    pop_s        = 1'b0;
    demand_s     = 3'd0;
    issue_s      = 1'b0;
    eol_s        = 1'b0;
    last_s       = 1'b0;
    last_issue_s = 1'b0;
    head_last_s  = 1'b0;
    occ_d        = occ_q;

    pop_s    = (occ_q != 2'd0) && pix_ready;
    demand_s = {1'b0, occ_q} + {2'b00, pend_q} + 3'd1 - {2'b00, pop_s};
    if (state_q == ST_RUN) begin
      issue_s = (demand_s <= 3'd2);
    end else begin
      issue_s = 1'b0;
    end

    eol_s        = (x_q == X_LAST);
    last_s       = eol_s && (y_q == Y_LAST);
    last_issue_s = issue_s && (k_q == K_LAST);
    head_last_s  = fifo_last_q[rd_ptr_q];

    case ({pend_q, pop_s})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  // Frame sequencing, read-address generation and raster position tagging.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      next_addr_q <= {ADDR_WIDTH{1'b0}};
      last_addr_q <= {ADDR_WIDTH{1'b0}};
      k_q         <= {KW{1'b0}};
      x_q         <= {XW{1'b0}};
      y_q         <= {YW{1'b0}};
      pend_q      <= 1'b0;
      pend_eol_q  <= 1'b0;
      pend_last_q <= 1'b0;
    end else begin
      done_q      <= 1'b0;
      pend_q      <= issue_s;
      pend_eol_q  <= eol_s;
      pend_last_q <= last_s;

      if (issue_s) begin
        last_addr_q <= next_addr_q;
        next_addr_q <= next_addr_q + ADDR_WIDTH'(1);
        k_q         <= k_q + KW'(1);
        if (eol_s) begin
          x_q <= {XW{1'b0}};
          y_q <= last_s ? {YW{1'b0}} : y_q + YW'(1);
        end else begin
          x_q <= x_q + XW'(1);
        end
      end

      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q     <= ST_RUN;
            busy_q      <= 1'b1;
            next_addr_q <= base_addr;
            k_q         <= {KW{1'b0}};
            x_q         <= {XW{1'b0}};
            y_q         <= {YW{1'b0}};
          end
        end
        ST_RUN: begin
          if (last_issue_s) begin
            state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (pop_s && head_last_s) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Two-entry output FIFO; a read lands here exactly one cycle after it was issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_data_q[0] <= {DATA_WIDTH{1'b0}};
      fifo_data_q[1] <= {DATA_WIDTH{1'b0}};
      fifo_eol_q     <= 2'b00;
      fifo_last_q    <= 2'b00;
      rd_ptr_q       <= 1'b0;
      wr_ptr_q       <= 1'b0;
      occ_q          <= 2'd0;
    end else begin
      if (pend_q) begin
        fifo_data_q[wr_ptr_q] <= mem_dout;
        fifo_eol_q[wr_ptr_q]  <= pend_eol_q;
        fifo_last_q[wr_ptr_q] <= pend_last_q;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      occ_q <= occ_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign mem_cen   = ~issue_s;
  assign mem_wen   = 1'b0;
  assign mem_addr  = issue_s ? next_addr_q : last_addr_q;
  assign pix_valid = (occ_q != 2'd0);
  assign pix_data  = fifo_data_q[rd_ptr_q];
  assign pix_eol   = fifo_eol_q[rd_ptr_q];
  assign pix_last  = head_last_s;

endmodule

// File: tb/tb_fb_scan_reader.sv
// Bench for fb_scan_reader: bram model with mem[i]=i, a stream/address reference model checked
// every cycle, a latency table for a full-rate frame, and stall / restart / reset sequences.
module tb_fb_scan_reader;

  localparam int AW  = 12;
  localparam int DW  = 24;
  localparam int H   = 64;
  localparam int V   = 64;
  localparam int TOT = H * V;
  localparam int MSZ = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic          busy;
  logic          done;
  logic          mem_cen;
  logic          mem_wen;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_dout = '0;
  logic          pix_valid;
  logic          pix_ready;
  logic [DW-1:0] pix_data;
  logic          pix_eol;
  logic          pix_last;

  logic [DW-1:0] mem [0:MSZ-1];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // reference model state
  bit            mon_en = 1'b0;
  int            exp_base = 0;
  int            issued = 0;
  int            popped = 0;
  bit            prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;

  typedef struct {
    int off;
    int cen;
    int valid;
    int busy;
    int done;
  } tvec_t;
  tvec_t tv [9];
  bit    tim_en = 1'b0;
  int    tim_start = 0;

  always #5 clk = ~clk;

  fb_scan_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .H_RES(H), .V_RES(V)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .busy(busy), .done(done),
    .mem_cen(mem_cen), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_dout(mem_dout),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .pix_eol(pix_eol), .pix_last(pix_last)
  );

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!mem_cen) mem_dout <= mem[mem_addr];
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: pixel j of a frame is address (base+j) mod 2^AW, eol every H-th, last at TOT-1.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("outstanding_le2", int'((issued - popped) <= 2), 1);
      if (!mem_cen) begin
        chk("mem_addr", int'(mem_addr), (exp_base + issued) % MSZ);
        chk("mem_wen", int'(mem_wen), 0);
        chk("read_count", int'(issued < TOT), 1);
        issued++;
      end
      if (prev_stall) begin
        chk("hold_valid", int'(pix_valid), 1);
        chk("hold_data", int'(pix_data), int'(prev_data));
      end
      if (pix_valid && pix_ready) begin
        chk("pix_data", int'(pix_data), (exp_base + popped) % MSZ);
        chk("pix_eol", int'(pix_eol), int'((popped % H) == H - 1));
        chk("pix_last", int'(pix_last), int'(popped == TOT - 1));
        popped++;
        prev_stall = 1'b0;
      end else begin
        prev_stall = pix_valid;
        prev_data  = pix_data;
      end
    end
    if (tim_en) begin
      for (int i = 0; i < 9; i++) begin
        if (cyc - tim_start == tv[i].off) begin
          chk($sformatf("t%0d_cen", tv[i].off), int'(mem_cen), tv[i].cen);
          chk($sformatf("t%0d_valid", tv[i].off), int'(pix_valid), tv[i].valid);
          chk($sformatf("t%0d_busy", tv[i].off), int'(busy), tv[i].busy);
          chk($sformatf("t%0d_done", tv[i].off), int'(done), tv[i].done);
        end
      end
    end
  end

  task automatic model_reset(input int base);
    exp_base   = base;
    issued     = 0;
    popped     = 0;
    prev_stall = 1'b0;
    mon_en     = 1'b1;
  endtask

  // Starts a frame in the current cycle and returns in the cycle where done is high.
  task automatic run_frame(input int base, input int pct, input int pulse_at);
    int n;
    n = 0;
    base_addr = AW'(base);
    start     = 1'b1;
    model_reset(base);
    pix_ready = (int'($urandom_range(0, 99)) < pct);
    do begin
      tick();
      n++;
      start = 1'b0;
      if (n == pulse_at) begin
        start     = 1'b1;
        base_addr = 12'h800;
      end
      if (done !== 1'b1) pix_ready = (int'($urandom_range(0, 99)) < pct);
    end while (done !== 1'b1 && n < 20000);
    chk("frame_done", int'(done), 1);
    chk("frame_pixels", popped, TOT);
    chk("frame_reads", issued, TOT);
  endtask

  initial begin
    int rel;
    int guard;

    for (int i = 0; i < MSZ; i++) mem[i] = DW'(i);
    tv[0] = '{1,    0, 0, 1, 0};
    tv[1] = '{2,    0, 0, 1, 0};
    tv[2] = '{3,    0, 1, 1, 0};
    tv[3] = '{2000, 0, 1, 1, 0};
    tv[4] = '{4096, 0, 1, 1, 0};
    tv[5] = '{4097, 1, 1, 1, 0};
    tv[6] = '{4098, 1, 1, 1, 0};
    tv[7] = '{4099, 1, 0, 0, 1};
    tv[8] = '{4100, 0, 0, 1, 0};

    rst = 1'b1; start = 1'b0; pix_ready = 1'b0; base_addr = '0;
    tick(); tick();
    @(negedge clk);
    chk("rst_mem_cen", int'(mem_cen), 1);
    chk("rst_mem_wen", int'(mem_wen), 0);
    chk("rst_mem_addr", int'(mem_addr), 0);
    chk("rst_pix_valid", int'(pix_valid), 0);
    chk("rst_pix_data", int'(pix_data), 0);
    chk("rst_pix_eol", int'(pix_eol), 0);
    chk("rst_pix_last", int'(pix_last), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    tick();
    rst = 1'b0;
    tick();

    run_frame(12'h123, 80, -1);
    // full-rate frame started in the previous frame's done cycle
    tim_start = cyc;
    tim_en    = 1'b1;
    run_frame(0, 100, -1);
    // start pulsed mid-frame must be ignored
    run_frame(0, 50, 500);
    run_frame(12'hFF0, 50, -1);

    // stall right after start: exactly two reads, pixel 0 held
    base_addr = '0;
    start     = 1'b1;
    pix_ready = 1'b0;
    model_reset(0);
    tick();
    start = 1'b0;
    repeat (99) tick();
    @(negedge clk);
    chk("stall_reads", issued, 2);
    chk("stall_cen", int'(mem_cen), 1);
    chk("stall_valid", int'(pix_valid), 1);
    chk("stall_data", int'(pix_data), 0);
    chk("stall_busy", int'(busy), 1);
    tick();
    pix_ready = 1'b1;
    rel = cyc;
    guard = 0;
    while (done !== 1'b1 && guard < 10000) begin
      tick();
      guard++;
    end
    chk("gapfree_done_cycle", cyc - rel, 4096);
    chk("stall_pixels", popped, TOT);

    // reset at pixel 1000 aborts the frame
    base_addr = 12'h200;
    start     = 1'b1;
    pix_ready = 1'b1;
    model_reset(12'h200);
    tick();
    start = 1'b0;
    guard = 0;
    while (popped < 1000 && guard < 5000) begin
      tick();
      guard++;
    end
    chk("abort_at_px1000", popped, 1000);
    rst    = 1'b1;
    mon_en = 1'b0;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("abort_cen", int'(mem_cen), 1);
    chk("abort_valid", int'(pix_valid), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_data", int'(pix_data), 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("abort_no_done", int'(done), 0);
    end
    run_frame(12'h700, 50, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
